// File: rtl/fifo_buffer_param_if.sv
// fifo_buffer_param_if: write/read handshake and status bundle for the FIFO
interface fifo_buffer_param_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
);
  logic [DATA_WIDTH-1:0] DATA_IN;
  logic                  WRITE;
  logic                  Valid;
  logic                  READ;
  logic [DATA_WIDTH-1:0] DATA_OUT;
  logic                  VALID_OUT;
  logic [ADDR_WIDTH:0]   COUNT;
  logic                  FULL;
  logic                  EMPTY;
  logic                  ALMOST_FULL;
  logic                  ALMOST_EMPTY;
  logic                  OVERFLOW;
  logic                  UNDERFLOW;
  modport master (
    output DATA_IN, WRITE, Valid, READ,
    input  DATA_OUT, VALID_OUT, COUNT, FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY, OVERFLOW, UNDERFLOW
  );
  modport slave (
    input  DATA_IN, WRITE, Valid, READ,
    output DATA_OUT, VALID_OUT, COUNT, FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY, OVERFLOW, UNDERFLOW
  );
endinterface

// File: rtl/fifo_buffer_param.sv
// fifo_buffer_param: synchronous FIFO with registered read data, occupancy flags and sticky error flags
module fifo_buffer_param #(
  parameter int DATA_WIDTH      = 8,
  parameter int ADDR_WIDTH      = 3,
  parameter int ALMOST_FULL_TH  = 6,
  parameter int ALMOST_EMPTY_TH = 2
) (
  input logic CLK,
  input logic RESET,
  fifo_buffer_param_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_CNT   = (ADDR_WIDTH + 1)'(ALMOST_FULL_TH);
  localparam logic [ADDR_WIDTH:0] AE_CNT   = (ADDR_WIDTH + 1)'(ALMOST_EMPTY_TH);
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  valid_out_q, valid_out_d;
  logic                  overflow_q, overflow_d, underflow_q, underflow_d;
  logic                  empty, full, wr_req, rd_en, wr_en;
  // Accept decisions, pointer/count advance and sticky error capture
  always_comb begin
    empty       = count_q == '0;
    full        = count_q == FULL_CNT;
    wr_req      = bus.WRITE && bus.Valid;
    rd_en       = bus.READ && !empty;
    wr_en       = wr_req && (!full || rd_en);
    wr_ptr_d    = wr_en ? wr_ptr_q + ADDR_WIDTH'(1) : wr_ptr_q;
    rd_ptr_d    = rd_en ? rd_ptr_q + ADDR_WIDTH'(1) : rd_ptr_q;
    count_d     = count_q + {{ADDR_WIDTH{1'b0}}, wr_en} - {{ADDR_WIDTH{1'b0}}, rd_en};
    data_out_d  = rd_en ? mem_q[rd_ptr_q] : data_out_q;
    valid_out_d = rd_en;
    overflow_d  = overflow_q || (wr_req && !wr_en);
    underflow_d = underflow_q || (bus.READ && empty);
  end
  // Control state; reset clears everything except memory
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end
  // Storage array; contents survive reset but become unreachable once pointers clear
  always_ff @(posedge CLK) begin
    if (wr_en && !RESET) mem_q[wr_ptr_q] <= bus.DATA_IN;
  end
  assign bus.DATA_OUT     = data_out_q;
  assign bus.VALID_OUT    = valid_out_q;
  assign bus.COUNT        = count_q;
  assign bus.FULL         = full;
  assign bus.EMPTY        = empty;
  assign bus.ALMOST_FULL  = count_q >= AF_CNT;
  assign bus.ALMOST_EMPTY = count_q <= AE_CNT;
  assign bus.OVERFLOW     = overflow_q;
  assign bus.UNDERFLOW    = underflow_q;
endmodule

// File: tb/tb_fifo_buffer_param.sv
// tb_fifo_buffer_param: table vectors, directed corner sequences and random traffic against a queue model
module tb_fifo_buffer_param;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  fifo_buffer_param_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) bus ();
  fifo_buffer_param #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .ALMOST_FULL_TH(6), .ALMOST_EMPTY_TH(2)) dut (
    .CLK(clk), .RESET(rst), .bus(bus)
  );
  int checks = 0;
  int failures = 0;
  logic [7:0] q[$];
  logic [7:0] m_dout = 8'h00;
  logic m_vout = 1'b0, m_of = 1'b0, m_uf = 1'b0;
  typedef struct {
    logic w, v, r;
    logic [7:0] d, dout;
    logic vout;
    logic [3:0] cnt;
    logic empty;
  } vec_t;
  vec_t tbl[16];
  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask
  task automatic check_all();
    chk("DATA_OUT", bus.DATA_OUT, m_dout);
    chk("VALID_OUT", bus.VALID_OUT, m_vout);
    chk("COUNT", bus.COUNT, q.size());
    chk("FULL", bus.FULL, q.size() == 8);
    chk("EMPTY", bus.EMPTY, q.size() == 0);
    chk("ALMOST_FULL", bus.ALMOST_FULL, q.size() >= 6);
    chk("ALMOST_EMPTY", bus.ALMOST_EMPTY, q.size() <= 2);
    chk("OVERFLOW", bus.OVERFLOW, m_of);
    chk("UNDERFLOW", bus.UNDERFLOW, m_uf);
  endtask
  task automatic model_clear();
    q.delete();
    m_dout = 8'h00;
    m_vout = 1'b0;
    m_of = 1'b0;
    m_uf = 1'b0;
  endtask
  task automatic step(input logic w, input logic v, input logic r, input logic [7:0] d);
    bit rd_ok, wr_ok;
    bus.WRITE = w;
    bus.Valid = v;
    bus.READ = r;
    bus.DATA_IN = d;
    rd_ok = r && q.size() > 0;
    wr_ok = w && v && (q.size() < 8 || rd_ok);
    if (r && q.size() == 0) m_uf = 1'b1;
    if (w && v && !wr_ok) m_of = 1'b1;
    m_vout = rd_ok;
    if (rd_ok) m_dout = q.pop_front();
    if (wr_ok) q.push_back(d);
    @(posedge clk);
    #1;
    check_all();
  endtask
  task automatic do_reset();
    bus.WRITE = 1'b0;
    bus.Valid = 1'b0;
    bus.READ = 1'b0;
    rst = 1'b1;
    #2;
    model_clear();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;
  endtask
  initial begin
    bus.WRITE = 1'b0;
    bus.Valid = 1'b0;
    bus.READ = 1'b0;
    bus.DATA_IN = 8'h00;
    tbl[0]  = '{1, 0, 0, 8'h77, 8'h00, 0, 4'd0, 1};
    tbl[1]  = '{1, 1, 0, 8'hAA, 8'h00, 0, 4'd1, 0};
    tbl[2]  = '{1, 1, 0, 8'hBB, 8'h00, 0, 4'd2, 0};
    tbl[3]  = '{1, 1, 0, 8'hCC, 8'h00, 0, 4'd3, 0};
    tbl[4]  = '{1, 1, 0, 8'hDD, 8'h00, 0, 4'd4, 0};
    tbl[5]  = '{1, 1, 0, 8'hEE, 8'h00, 0, 4'd5, 0};
    tbl[6]  = '{0, 0, 1, 8'h00, 8'hAA, 1, 4'd4, 0};
    tbl[7]  = '{0, 0, 1, 8'h00, 8'hBB, 1, 4'd3, 0};
    tbl[8]  = '{0, 0, 1, 8'h00, 8'hCC, 1, 4'd2, 0};
    tbl[9]  = '{0, 0, 1, 8'h00, 8'hDD, 1, 4'd1, 0};
    tbl[10] = '{0, 0, 1, 8'h00, 8'hEE, 1, 4'd0, 1};
    tbl[11] = '{0, 0, 0, 8'h00, 8'hEE, 0, 4'd0, 1};
    tbl[12] = '{1, 1, 0, 8'h3C, 8'hEE, 0, 4'd1, 0};
    tbl[13] = '{1, 1, 1, 8'h5A, 8'h3C, 1, 4'd1, 0};
    tbl[14] = '{0, 0, 1, 8'h00, 8'h5A, 1, 4'd0, 1};
    tbl[15] = '{0, 1, 0, 8'h11, 8'h5A, 0, 4'd0, 1};
    do_reset();
    for (int i = 0; i < 16; i++) begin
      step(tbl[i].w, tbl[i].v, tbl[i].r, tbl[i].d);
      chk($sformatf("tbl%0d DATA_OUT", i), bus.DATA_OUT, tbl[i].dout);
      chk($sformatf("tbl%0d VALID_OUT", i), bus.VALID_OUT, tbl[i].vout);
      chk($sformatf("tbl%0d COUNT", i), bus.COUNT, tbl[i].cnt);
      chk($sformatf("tbl%0d EMPTY", i), bus.EMPTY, tbl[i].empty);
    end
    chk("no overflow from Valid=0", bus.OVERFLOW, 0);
    for (int i = 1; i <= 8; i++) begin
      step(1, 1, 0, 8'(i));
      chk("AF from 6", bus.ALMOST_FULL, i >= 6);
    end
    chk("FULL at 8", bus.FULL, 1);
    step(1, 1, 0, 8'hFF);
    chk("overflow set", bus.OVERFLOW, 1);
    chk("count held at 8", bus.COUNT, 8);
    step(1, 1, 1, 8'h99);
    chk("full rw oldest out", bus.DATA_OUT, 8'h01);
    chk("full rw count", bus.COUNT, 8);
    for (int i = 2; i <= 8; i++) begin
      step(0, 0, 1, 8'h00);
      chk("drain order", bus.DATA_OUT, i);
    end
    step(0, 0, 1, 8'h00);
    chk("99 read last", bus.DATA_OUT, 8'h99);
    step(0, 0, 1, 8'h00);
    chk("empty read no valid", bus.VALID_OUT, 0);
    chk("empty read data held", bus.DATA_OUT, 8'h99);
    chk("underflow set", bus.UNDERFLOW, 1);
    step(0, 0, 0, 8'h00);
    step(0, 0, 0, 8'h00);
    chk("underflow sticky", bus.UNDERFLOW, 1);
    step(1, 1, 1, 8'h42);
    chk("empty rw write only", bus.COUNT, 1);
    do_reset();
    chk("reset clears underflow", bus.UNDERFLOW, 0);
    for (int k = 0; k < 3; k++) for (int i = 0; i < 6; i++) step(k != 1, k != 1, k == 1, 8'(8'h20 + k * 8 + i));
    chk("wrap count", bus.COUNT, 6);
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 1, 8'h00);
      chk("wrap order", bus.DATA_OUT, 8'h30 + i);
    end
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 1, 0, 8'(8'hB0 + i));
    chk("pre-reset count", bus.COUNT, 3);
    bus.WRITE = 1'b1;
    bus.Valid = 1'b1;
    bus.READ = 1'b1;
    bus.DATA_IN = 8'h55;
    #2;
    rst = 1'b1;
    #1;
    model_clear();
    chk("async reset count", bus.COUNT, 0);
    check_all();
    @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;
    step(1, 1, 0, 8'hA6);
    step(0, 0, 1, 8'h00);
    chk("A6 after reset", bus.DATA_OUT, 8'hA6);
    for (int i = 0; i < 600; i++) begin
      if (i % 150 == 149) do_reset();
      else step($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 85, $urandom_range(0, 99) < (i % 100 < 50 ? 35 : 65), 8'($urandom));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fifo_buffer_param.md
FIFO_BUFFER_PARAM -- requirements
Module: fifo_buffer_param

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: bit width of each stored word.
REQ-002 SHALL have parameter ADDR_WIDTH, default 3: depth is 2**ADDR_WIDTH entries (8 by default).
REQ-003 SHALL have parameter ALMOST_FULL_TH, default 6: ALMOST_FULL asserts when COUNT >= this value.
REQ-004 SHALL have parameter ALMOST_EMPTY_TH, default 2: ALMOST_EMPTY asserts when COUNT <= this value.
REQ-005 SHALL have port CLK  input  1  single clock; all state changes on its rising edge.
REQ-006 SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port DATA_IN  input  DATA_WIDTH  write data.
REQ-008 SHALL have port WRITE  input  1  write request.
REQ-009 SHALL have port Valid  input  1  DATA_IN qualifier; a write request requires WRITE=1 and Valid=1.
REQ-010 SHALL have port READ  input  1  read request.
REQ-011 SHALL have port DATA_OUT  output  DATA_WIDTH  registered read data.
REQ-012 SHALL have port VALID_OUT  output  1  DATA_OUT holds a newly read word this cycle.
REQ-013 SHALL have port COUNT  output  ADDR_WIDTH+1  number of stored words, 0..2**ADDR_WIDTH.
REQ-014 SHALL have ports FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY  output  1 each  occupancy flags.
REQ-015 SHALL have ports OVERFLOW, UNDERFLOW  output  1 each  sticky error flags.

Function
REQ-016 SHALL accept a write on a rising edge when WRITE=1, Valid=1, and (FULL=0 or a read is accepted on the same edge), storing DATA_IN at the write pointer.
REQ-017 SHALL accept a read on a rising edge when READ=1 and EMPTY=0, loading DATA_OUT with the word at the read pointer and driving VALID_OUT=1 for exactly that following cycle.
REQ-018 SHALL make a word written on edge N readable by a READ sampled on edge N+1 (no same-edge fall-through), with DATA_OUT valid after edge N+1.
REQ-019 SHALL hold DATA_OUT at its last read value and drive VALID_OUT=0 in every cycle following an edge with no accepted read.
REQ-020 SHALL advance each pointer modulo 2**ADDR_WIDTH, wrapping from the last entry to 0.
REQ-021 SHALL update COUNT by +1 on write only, -1 on read only, and hold it on simultaneous accepted read and write.
REQ-022 SHALL derive FULL (COUNT=2**ADDR_WIDTH), EMPTY (COUNT=0), ALMOST_FULL and ALMOST_EMPTY combinationally from COUNT.
REQ-023 SHALL, at FULL with simultaneous write and read requests, accept both, so COUNT remains at depth.
REQ-024 SHALL, at EMPTY with simultaneous write and read requests, accept only the write, ignore the read, and set UNDERFLOW.
REQ-025 SHALL drop a write request made while FULL with no accepted read, leave memory and pointers unchanged, and set OVERFLOW.
REQ-026 SHALL ignore a read request made while EMPTY, leave DATA_OUT unchanged with VALID_OUT=0, and set UNDERFLOW.
REQ-027 SHALL ignore WRITE=1 with Valid=0 and SHALL not treat it as an overflow.
REQ-028 SHALL keep OVERFLOW and UNDERFLOW asserted once set, until RESET.

Reset
REQ-029 SHALL, on RESET=1, immediately and asynchronously clear both pointers, COUNT, DATA_OUT, VALID_OUT, OVERFLOW and UNDERFLOW to 0, giving EMPTY=1, ALMOST_EMPTY=1, FULL=0 and ALMOST_FULL=0.
REQ-030 SHALL not clear memory contents on reset and SHALL make them unreachable until rewritten.
REQ-031 SHALL, while RESET=1, accept neither writes nor reads; an operation in progress when reset asserts is discarded.

Verification
REQ-032 SHALL pass: write AA,BB,CC,DD,EE with Valid=1, then 5 reads -> DATA_OUT AA..EE in order with VALID_OUT=1 each cycle, then COUNT=0 and EMPTY=1.
REQ-033 SHALL pass: write 8 words 01..08 -> FULL=1 and ALMOST_FULL=1 from COUNT=6 onward; 9th write FF -> dropped, OVERFLOW=1; reads return 01..08.
REQ-034 SHALL pass: READ=1 on an empty FIFO -> VALID_OUT=0, DATA_OUT unchanged, UNDERFLOW=1 until RESET.
REQ-035 SHALL pass: at FULL, simultaneous WRITE of 99 and READ -> oldest word out, COUNT stays 8, and 99 is read last.
REQ-036 SHALL pass: 6 writes, 6 reads, then 6 writes (pointers wrap) -> data order preserved across the wrap and COUNT=6.
REQ-037 SHALL pass: RESET asserted mid-burst at COUNT=3 -> flags and outputs cleared within the same cycle; a following write of A6 then read returns A6.
